// File: rtl/macrocell_cfg_loader_pkg.sv
// Shared definitions for the macrocell configuration loader: the per-macrocell
// config word layout, its width, and the loader FSM state encoding.
package macrocell_cfg_loader_pkg;

    // One macrocell's mux settings. Packed MSB first, so gclk_mux lands in bits
    // 20..19 and pt1_mux in bit 0.
    typedef struct packed {
        logic [1:0] gclk_mux;   // bits 20..19
        logic [2:0] oe_mux;     // bits 18..16
        logic       o_mux;      // bit 15
        logic       fb_mux;     // bit 14
        logic       storage_mux;// bit 13
        logic       dfast_mux;  // bit 12
        logic       d_mux;      // bit 11
        logic       xor_inv_mux;// bit 10
        logic       xor_b_mux;  // bit 9
        logic       xor_a_mux;  // bit 8
        logic       pt5_func;   // bit 7
        logic       pt4_func;   // bit 6
        logic       gclr_mux;   // bit 5
        logic       pt5_mux;    // bit 4
        logic       pt4_mux;    // bit 3
        logic       pt3_mux;    // bit 2
        logic       pt2_mux;    // bit 1
        logic       pt1_mux;    // bit 0
    } mc_cfg_t;

    localparam int CFG_W = $bits(mc_cfg_t);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHIFT  = 2'd1,
        ST_CHECK  = 2'd2,
        ST_COMMIT = 2'd3
    } cfg_state_t;

endpackage

// File: rtl/macrocell_cfg_loader_if.sv
// Serial configuration port plus status and the active config bus.
//
// Handshake: a serial bit on cfg_bit_v is consumed on every rising clock edge
// where cfg_valid_v and cfg_ready are both high; cfg_ready never depends on
// cfg_valid_v. cfg_start_v, cfg_commit_v and cfg_err_clr_v are single-cycle
// pulses with no handshake. cfg_ok / cfg_err are one-cycle result pulses.
interface macrocell_cfg_loader_if #(
    parameter int NUM_MC = 16,
    parameter int WORD_W = macrocell_cfg_loader_pkg::CFG_W
);
    logic                          cfg_start_v;
    logic                          cfg_bit_v;
    logic                          cfg_valid_v;
    logic                          cfg_ready;
    logic                          cfg_commit_v;
    logic                          cfg_err_clr_v;
    logic                          cfg_ok;
    logic                          cfg_err;
    logic                          cfg_err_sticky;
    logic                          cfg_busy;
    logic [NUM_MC*WORD_W-1:0]      mc_cfg_mux;
    macrocell_cfg_loader_pkg::cfg_state_t state_dbg;

    modport master (
        output cfg_start_v, cfg_bit_v, cfg_valid_v, cfg_commit_v, cfg_err_clr_v,
        input  cfg_ready, cfg_ok, cfg_err, cfg_err_sticky, cfg_busy, mc_cfg_mux, state_dbg
    );

    modport slave (
        input  cfg_start_v, cfg_bit_v, cfg_valid_v, cfg_commit_v, cfg_err_clr_v,
        output cfg_ready, cfg_ok, cfg_err, cfg_err_sticky, cfg_busy, mc_cfg_mux, state_dbg
    );
endinterface

// File: rtl/macrocell_cfg_loader_bank.sv
// Shadow and active configuration banks. Frames land in the shadow bank one
// word at a time; a commit copies the whole shadow bank into the active bank
// in a single edge so macrocells never see a half-loaded configuration.
module mc_cfg_bank
    import macrocell_cfg_loader_pkg::*;
#(
    parameter int NUM_MC = 16,
    parameter int ADDR_W = 4
) (
    input  logic                      clk_v,
    input  logic                      rst_v,
    input  logic                      we,
    input  logic [ADDR_W-1:0]         waddr,
    input  mc_cfg_t                   wdata,
    input  logic                      commit,
    output logic [NUM_MC*CFG_W-1:0]   active_flat
);
    mc_cfg_t shadow_q [NUM_MC];
    mc_cfg_t shadow_d [NUM_MC];
    mc_cfg_t active_q [NUM_MC];
    mc_cfg_t active_d [NUM_MC];

    // Next-state for both banks: single-word shadow write, whole-bank commit.
    always_comb begin
        shadow_d = shadow_q;
        active_d = active_q;
        for (int i = 0; i < NUM_MC; i++) begin
            if (we && (waddr == ADDR_W'(i))) begin
                shadow_d[i] = wdata;
            end
        end
        if (commit) begin
            active_d = shadow_q;
        end
    end

    // Bank registers; reset clears both banks.
    always_ff @(posedge clk_v or posedge rst_v) begin
        if (rst_v) begin
            shadow_q <= '{default: '0};
            active_q <= '{default: '0};
        end else begin
            shadow_q <= shadow_d;
            active_q <= active_d;
        end
    end

    // Flatten the active bank onto the macrocell mux bus.
    always_comb begin
        active_flat = '0;
        for (int i = 0; i < NUM_MC; i++) begin
            active_flat[i*CFG_W +: CFG_W] = active_q[i];
        end
    end

endmodule

// File: rtl/macrocell_cfg_loader.sv
// Serial configuration controller: shifts in framed words MSB first
// (address, config word, even parity), validates each frame, writes good ones
// to the shadow bank and copies shadow to active on commit.
module macrocell_cfg_loader
    import macrocell_cfg_loader_pkg::*;
#(
    parameter int NUM_MC = 16,
    parameter int ADDR_W = 4
) (
    input  logic                 clk_v,
    input  logic                 rst_v,
    macrocell_cfg_loader_if.slave cfg
);
    localparam int FRAME_W = ADDR_W + CFG_W + 1;
    localparam int CNT_W   = $clog2(FRAME_W + 1);
    localparam logic [CNT_W-1:0]  LAST_BIT = CNT_W'(FRAME_W - 1);
    localparam logic [ADDR_W:0]   NUM_MC_L = (ADDR_W + 1)'(NUM_MC);

    cfg_state_t          state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [FRAME_W-1:0]  frame_q, frame_d;
    logic                pending_q, pending_d;      // commit waiting for frame to finish
    logic                start_pend_q, start_pend_d;// start seen in CHECK/COMMIT
    logic                ok_q, ok_d;
    logic                err_q, err_d;
    logic                sticky_q, sticky_d;

    logic                bank_we;
    logic                bank_commit;
    logic [ADDR_W-1:0]   frame_addr;
    mc_cfg_t             frame_word;
    logic                parity_ok;
    logic                addr_ok;
    logic [NUM_MC*CFG_W-1:0] active_flat;

    assign frame_addr = frame_q[FRAME_W-1 -: ADDR_W];
    assign frame_word = mc_cfg_t'(frame_q[CFG_W:1]);
    assign parity_ok  = ~(^frame_q);
    assign addr_ok    = ({1'b0, frame_addr} < NUM_MC_L);

    // Next-state, frame shifting, validation and status pulses.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        frame_d      = frame_q;
        pending_d    = pending_q;
        start_pend_d = start_pend_q;
        ok_d         = 1'b0;
        err_d        = 1'b0;
        sticky_d     = sticky_q & ~cfg.cfg_err_clr_v;
        bank_we      = 1'b0;
        bank_commit  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (cfg.cfg_commit_v) begin
                    // Commit goes first; a simultaneous start waits for it.
                    state_d = ST_COMMIT;
                    if (cfg.cfg_start_v) begin
                        start_pend_d = 1'b1;
                    end
                end else if (cfg.cfg_start_v || start_pend_q) begin
                    state_d      = ST_SHIFT;
                    cnt_d        = '0;
                    start_pend_d = 1'b0;
                end
            end
            ST_SHIFT: begin
                if (cfg.cfg_commit_v) begin
                    pending_d = 1'b1;
                end
                if (cfg.cfg_start_v) begin
                    // Restart: drop the partial frame silently.
                    cnt_d = '0;
                end else if (cfg.cfg_valid_v) begin
                    frame_d = {frame_q[FRAME_W-2:0], cfg.cfg_bit_v};
                    cnt_d   = cnt_q + 1'b1;
                    if (cnt_q == LAST_BIT) begin
                        state_d = ST_CHECK;
                    end
                end
            end
            ST_CHECK: begin
                if (cfg.cfg_start_v) begin
                    start_pend_d = 1'b1;
                end
                if (parity_ok && addr_ok) begin
                    bank_we = 1'b1;
                    ok_d    = 1'b1;
                end else begin
                    err_d    = 1'b1;
                    sticky_d = 1'b1;
                end
                if (pending_q || cfg.cfg_commit_v) begin
                    pending_d = 1'b1;
                    state_d   = ST_COMMIT;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_COMMIT: begin
                if (cfg.cfg_start_v) begin
                    start_pend_d = 1'b1;
                end
                // A sticky error blocks the copy so a bad load never goes live.
                bank_commit = ~sticky_q;
                pending_d   = 1'b0;
                state_d     = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Control and status registers.
    always_ff @(posedge clk_v or posedge rst_v) begin
        if (rst_v) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            frame_q      <= '0;
            pending_q    <= 1'b0;
            start_pend_q <= 1'b0;
            ok_q         <= 1'b0;
            err_q        <= 1'b0;
            sticky_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            frame_q      <= frame_d;
            pending_q    <= pending_d;
            start_pend_q <= start_pend_d;
            ok_q         <= ok_d;
            err_q        <= err_d;
            sticky_q     <= sticky_d;
        end
    end

    mc_cfg_bank #(
        .NUM_MC (NUM_MC),
        .ADDR_W (ADDR_W)
    ) u_bank (
        .clk_v       (clk_v),
        .rst_v       (rst_v),
        .we          (bank_we),
        .waddr       (frame_addr),
        .wdata       (frame_word),
        .commit      (bank_commit),
        .active_flat (active_flat)
    );

    assign cfg.cfg_ready      = (state_q == ST_SHIFT);
    assign cfg.cfg_busy       = (state_q != ST_IDLE) || pending_q;
    assign cfg.cfg_ok         = ok_q;
    assign cfg.cfg_err        = err_q;
    assign cfg.cfg_err_sticky = sticky_q;
    assign cfg.mc_cfg_mux     = active_flat;
    assign cfg.state_dbg      = state_q;

endmodule
